// File: rtl/seg_pkg.sv
// Shared constants and types for the segment address unit.
package seg_pkg;

  // Segment register indices (extras above ES are general purpose)
  localparam int unsigned SEG_CS = 0;
  localparam int unsigned SEG_DS = 1;
  localparam int unsigned SEG_SS = 2;
  localparam int unsigned SEG_ES = 3;

  // Default geometry for the 8086-style 20-bit address space
  localparam int unsigned DEF_SHIFT  = 4;
  localparam int unsigned DEF_ADDR_W = 20;

  // Segment-override prefix tracker
  typedef enum logic {
    OVR_IDLE  = 1'b0,
    OVR_ARMED = 1'b1
  } ovr_state_t;

endpackage

// File: rtl/seg_addr_gen.sv
// Combinational physical-address generator: (seg << SHIFT) + off, truncated.
// Optional feature macro: SEG_LIMIT_EN adds an offset-vs-limit fault compare.
module seg_addr_gen #(
  parameter int unsigned SEG_W  = 16,
  parameter int unsigned OFF_W  = 16,
  parameter int unsigned SHIFT  = 4,
  parameter int unsigned ADDR_W = 20
) (
  input  logic [SEG_W-1:0]  seg,
  input  logic [OFF_W-1:0]  off,
`ifdef SEG_LIMIT_EN
  input  logic [OFF_W-1:0]  limit,
  output logic              fault,
`endif
  output logic [ADDR_W-1:0] addr
);

  // Sum is formed wide enough for both operands and the result, then truncated
  localparam int unsigned OPS_W = (SEG_W + SHIFT > OFF_W) ? SEG_W + SHIFT : OFF_W;
  localparam int unsigned SUM_W = (OPS_W > ADDR_W) ? OPS_W : ADDR_W;

  logic [SUM_W-1:0] seg_ext;
  logic [SUM_W-1:0] off_ext;
  logic [SUM_W-1:0] sum;

  // Shift-add; any carry beyond ADDR_W is discarded (address wrap)
  always_comb begin
    seg_ext = SUM_W'(seg) << SHIFT;
    off_ext = SUM_W'(off);
    sum     = seg_ext + off_ext;
    addr    = sum[ADDR_W-1:0];
  end

`ifdef SEG_LIMIT_EN
  // Fault when the offset exceeds the segment limit
  always_comb begin
    fault = (off > limit);
  end
`endif

endmodule

// File: rtl/seg_addr_unit.sv
// Segment register file, override-prefix FSM and registered address response.
// Optional feature macro: SEG_LIMIT_EN adds per-segment limit registers,
// the lim_wr_* ports and a registered rsp_fault; otherwise rsp_fault is 0.
module seg_addr_unit
  import seg_pkg::*;
#(
  parameter int unsigned     SEG_W   = 16,
  parameter int unsigned     OFF_W   = 16,
  parameter int unsigned     NUM_SEG = 4,
  parameter int unsigned     SEL_W   = $clog2(NUM_SEG),
  parameter int unsigned     SHIFT   = DEF_SHIFT,
  parameter int unsigned     ADDR_W  = DEF_ADDR_W,
  parameter logic [SEG_W-1:0] CS_RST = 16'hFFFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [SEL_W-1:0]         wr_sel,
  input  logic [SEG_W-1:0]         wr_data,
  output logic [NUM_SEG*SEG_W-1:0] seg_out,
`ifdef SEG_LIMIT_EN
  input  logic                     lim_wr_en,
  input  logic [SEL_W-1:0]         lim_wr_sel,
  input  logic [OFF_W-1:0]         lim_wr_data,
`endif
  input  logic                     ovr_valid,
  input  logic [SEL_W-1:0]         ovr_sel,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [SEL_W-1:0]         req_sel,
  input  logic [OFF_W-1:0]         req_off,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ADDR_W-1:0]        rsp_addr,
  output logic [SEL_W-1:0]         rsp_seg,
  output logic                     rsp_fault
);

  logic [SEG_W-1:0] seg_q [NUM_SEG];
  ovr_state_t       state;
  ovr_state_t       state_nxt;
  logic [SEL_W-1:0] ovr_q;
  logic [SEL_W-1:0] eff_sel;
  logic [SEG_W-1:0] eff_seg;
  logic [ADDR_W-1:0] gen_addr;
  logic             accept;
  logic             gen_fault;

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign eff_sel   = (state == OVR_ARMED) ? ovr_q : req_sel;

  // Segment register file; selectors outside the file match no entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_SEG; i++)
        seg_q[i] <= (i == SEG_CS) ? CS_RST : '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SEG; i++)
        if (wr_en && wr_sel == SEL_W'(i))
          seg_q[i] <= wr_data;
    end
  end

  for (genvar g = 0; g < NUM_SEG; g++) begin : g_seg_out
    assign seg_out[g*SEG_W +: SEG_W] = seg_q[g];
  end

  // Effective segment value, with same-cycle write bypass
  always_comb begin
    eff_seg = '0;
    for (int unsigned i = 0; i < NUM_SEG; i++) begin
      if (eff_sel == SEL_W'(i))
        eff_seg = (wr_en && wr_sel == eff_sel) ? wr_data : seg_q[i];
    end
  end

`ifdef SEG_LIMIT_EN
  logic [OFF_W-1:0] lim_q [NUM_SEG];
  logic [OFF_W-1:0] eff_lim;

  // Limit registers, reset to all-ones (no limit)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_SEG; i++)
        lim_q[i] <= '1;
    end else begin
      for (int unsigned i = 0; i < NUM_SEG; i++)
        if (lim_wr_en && lim_wr_sel == SEL_W'(i))
          lim_q[i] <= lim_wr_data;
    end
  end

  // Effective limit, with same-cycle write bypass
  always_comb begin
    eff_lim = '1;
    for (int unsigned i = 0; i < NUM_SEG; i++) begin
      if (eff_sel == SEL_W'(i))
        eff_lim = (lim_wr_en && lim_wr_sel == eff_sel) ? lim_wr_data : lim_q[i];
    end
  end

  seg_addr_gen #(
    .SEG_W  (SEG_W),
    .OFF_W  (OFF_W),
    .SHIFT  (SHIFT),
    .ADDR_W (ADDR_W)
  ) u_gen (
    .seg   (eff_seg),
    .off   (req_off),
    .limit (eff_lim),
    .fault (gen_fault),
    .addr  (gen_addr)
  );
`else
  assign gen_fault = 1'b0;

  seg_addr_gen #(
    .SEG_W  (SEG_W),
    .OFF_W  (OFF_W),
    .SHIFT  (SHIFT),
    .ADDR_W (ADDR_W)
  ) u_gen (
    .seg  (eff_seg),
    .off  (req_off),
    .addr (gen_addr)
  );
`endif

  // Override FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= OVR_IDLE;
    else      state <= state_nxt;
  end

  // Override FSM next state: a prefix always (re)arms, acceptance consumes it
  always_comb begin
    state_nxt = state;
    case (state)
      OVR_IDLE:  if (ovr_valid) state_nxt = OVR_ARMED;
      OVR_ARMED: if (accept && !ovr_valid) state_nxt = OVR_IDLE;
      default:   state_nxt = OVR_IDLE;
    endcase
  end

  // Latched override selector; the last prefix wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           ovr_q <= '0;
    else if (ovr_valid) ovr_q <= ovr_sel;
  end

  // Response register: load on acceptance, hold while stalled, drop when consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_seg   <= '0;
      rsp_fault <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_addr  <= gen_addr;
      rsp_seg   <= eff_sel;
      rsp_fault <= gen_fault;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_addr_unit.sv
// Self-checking bench for seg_addr_unit (default build, SEG_LIMIT_EN undefined).
module tb_seg_addr_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_sel = '0;
  logic [15:0] wr_data = '0;
  logic [63:0] seg_out;
  logic        ovr_valid = 1'b0;
  logic [1:0]  ovr_sel = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_sel = '0;
  logic [15:0] req_off = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [19:0] rsp_addr;
  logic [1:0]  rsp_seg;
  logic        rsp_fault;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [15:0] m_seg [4];
  bit          m_armed;
  logic [1:0]  m_ovr;
  bit          m_rv;
  logic [19:0] m_ra;
  logic [1:0]  m_rs;
  logic [19:0] sb [$];

  seg_addr_unit #(
    .SEG_W   (16),
    .OFF_W   (16),
    .NUM_SEG (4),
    .SHIFT   (4),
    .ADDR_W  (20),
    .CS_RST  (16'hFFFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .seg_out   (seg_out),
    .ovr_valid (ovr_valid),
    .ovr_sel   (ovr_sel),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_off   (req_off),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_addr  (rsp_addr),
    .rsp_seg   (rsp_seg),
    .rsp_fault (rsp_fault)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_seg_vec();
    logic [63:0] v;
    for (int i = 0; i < 4; i++) v[i*16 +: 16] = m_seg[i];
    return v;
  endfunction

  task automatic model_reset();
    m_seg[0] = 16'hFFFF;
    m_seg[1] = '0;
    m_seg[2] = '0;
    m_seg[3] = '0;
    m_armed  = 0;
    m_ovr    = '0;
    m_rv     = 0;
    m_ra     = '0;
    m_rs     = '0;
    sb.delete();
  endtask

  task automatic set_idle();
    wr_en     = 1'b0;
    ovr_valid = 1'b0;
    req_valid = 1'b0;
  endtask

  // Apply reset at a negedge, check immediate effect, hold two clocks, release
  task automatic do_reset();
    rst = 1'b0;
    set_idle();
    #1;
    model_reset();
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_req_ready", req_ready, 1);
    check_val("rst_rsp_addr", rsp_addr, 0);
    check_val("rst_rsp_seg", rsp_seg, 0);
    check_val("rst_rsp_fault", rsp_fault, 0);
    check_val("rst_seg_out", seg_out, 64'h0000_0000_0000_FFFF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock: predict from the driven inputs, advance, check at the negedge
  task automatic step();
    bit          rdy, acc, rr;
    logic [1:0]  eff;
    logic [15:0] sv;
    logic [31:0] sum;
    logic [19:0] a;
    #1;
    rr  = rsp_ready;
    rdy = !m_rv || rr;
    check_val("req_ready", req_ready, rdy);
    if (m_rv && rr) begin
      if (sb.size() == 0) check_val("sb_depth", sb.size(), 1);
      else                check_val("sb_addr", rsp_addr, sb.pop_front());
    end
    acc = req_valid && rdy;
    eff = m_armed ? m_ovr : req_sel;
    sv  = (wr_en && wr_sel == eff) ? wr_data : m_seg[eff];
    sum = ({16'h0, sv} << 4) + {16'h0, req_off};
    a   = sum[19:0];
    @(posedge clk);
    if (acc) begin
      m_rv = 1; m_ra = a; m_rs = eff;
      sb.push_back(a);
    end else if (rr) begin
      m_rv = 0;
    end
    m_armed = ovr_valid || (m_armed && !acc);
    if (ovr_valid) m_ovr = ovr_sel;
    if (wr_en) m_seg[wr_sel] = wr_data;
    @(negedge clk);
    check_val("rsp_valid", rsp_valid, m_rv);
    if (m_rv) begin
      check_val("rsp_addr", rsp_addr, m_ra);
      check_val("rsp_seg", rsp_seg, m_rs);
    end
    check_val("rsp_fault", rsp_fault, 0);
    check_val("seg_out", seg_out, model_seg_vec());
  endtask

  task automatic write_seg(input logic [1:0] s, input logic [15:0] d);
    set_idle();
    wr_en = 1'b1; wr_sel = s; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic request(input logic [1:0] s, input logic [15:0] o);
    set_idle();
    req_valid = 1'b1; req_sel = s; req_off = o;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Write DS then translate through it
    write_seg(2'd1, 16'h1234);
    check_val("ds_seg_out", seg_out[31:16], 16'h1234);
    request(2'd1, 16'h0005);
    check_val("ds_addr", rsp_addr, 20'h12345);
    check_val("ds_seg", rsp_seg, 1);

    // One-shot override to ES
    write_seg(2'd3, 16'h2000);
    set_idle(); ovr_valid = 1'b1; ovr_sel = 2'd3; step(); ovr_valid = 1'b0;
    request(2'd1, 16'h0010);
    check_val("ovr_addr", rsp_addr, 20'h20010);
    check_val("ovr_seg", rsp_seg, 3);
    request(2'd1, 16'h0010);
    check_val("ovr_clear_addr", rsp_addr, 20'h12350);
    check_val("ovr_clear_seg", rsp_seg, 1);

    // Address wrap and same-cycle write bypass
    request(2'd0, 16'h0010);
    check_val("wrap_addr", rsp_addr, 20'h00000);
    set_idle();
    wr_en = 1'b1; wr_sel = 2'd2; wr_data = 16'h0100;
    req_valid = 1'b1; req_sel = 2'd2; req_off = 16'h0000;
    step();
    check_val("bypass_addr", rsp_addr, 20'h01000);
    check_val("bypass_seg", rsp_seg, 2);

    // Back-pressure: response held, requests stalled
    set_idle();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_sel = 2'd1; req_off = 16'(i + 1);
      step();
      check_val("stall_addr", rsp_addr, 20'h01000);
      check_val("stall_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    req_off = 16'h0001;
    step();
    check_val("unstall_addr", rsp_addr, 20'h12341);
    set_idle();
    step();

    // Reset mid-operation: pending response and armed override both dropped
    ovr_valid = 1'b1; ovr_sel = 2'd3; req_valid = 1'b1; req_sel = 2'd1; req_off = 16'h0042;
    rsp_ready = 1'b0;
    step();
    set_idle();
    do_reset();
    rsp_ready = 1'b1;
    request(2'd1, 16'h0007);
    check_val("post_rst_seg", rsp_seg, 1);
    check_val("post_rst_addr", rsp_addr, 20'h00007);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_sel    = 2'($urandom_range(0, 3));
      wr_data   = 16'($urandom);
      ovr_valid = ($urandom_range(0, 6) == 0);
      ovr_sel   = 2'($urandom_range(0, 3));
      req_valid = ($urandom_range(0, 9) < 6);
      req_sel   = 2'($urandom_range(0, 3));
      req_off   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    // Drain and confirm every accepted request was delivered once
    set_idle();
    rsp_ready = 1'b1;
    step();
    step();
    check_val("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
